// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: digit width, digit limits
// and the run-control state encoding.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_LIMIT  = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_HI_LIMIT = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } sw_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..LIMIT on en, wraps to 0, and flags the carry
// in the same cycle it wraps so the next digit can advance with it.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = DIGIT_LIMIT
) (
    input  logic               cin,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LIMIT) ? '0 : q + 4'd1;
        end
    end

    assign carry = en & (q == LIMIT);

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch counting rising edges of the slow divider output, sampled
// as data on the fast clock, under start/stop/clear control.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic               cin,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               start_stop,
    input  logic               clear,
    output logic [DIGIT_W-1:0] sec_lo,
    output logic [DIGIT_W-1:0] sec_hi,
    output logic [DIGIT_W-1:0] min_lo,
    output logic [DIGIT_W-1:0] min_hi,
    output logic               running,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] MIN_HI_MAX = DIGIT_W'(MIN_MAX / 10);
    localparam logic [DIGIT_W-1:0] MIN_LO_MAX = DIGIT_W'(MIN_MAX % 10);

    sw_state_t state, state_next;
    logic      tick_prev;
    logic      tick_rise;
    logic      count_en;
    logic      at_max;
    logic      rollover;
    logic      digit_clr;
    logic      sec_lo_carry, sec_hi_carry, min_lo_carry, min_hi_carry;

    // tick_in already comes from a cin register, so a single delay stage is
    // enough for edge detection without a synchronizer.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_in;
        end
    end

    assign tick_rise = tick_in & ~tick_prev;

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            wrap    <= rollover;
        end
    end

    // clear beats start_stop; start_stop only toggles between RUN and PAUSE
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // A tick counts on the registered state, so start_stop in RUN still
    // lets the same-cycle tick through while the state moves to PAUSE.
    assign count_en = tick_rise & (state == RUN) & ~clear;

    assign at_max = (min_hi == MIN_HI_MAX) && (min_lo == MIN_LO_MAX) &&
                    (sec_hi == SEC_HI_LIMIT) && (sec_lo == DIGIT_LIMIT);

    assign rollover = count_en & at_max;

    // min_hi_carry only fires past the wrap point, so it is a backstop that
    // keeps the minute digits legal whatever MIN_MAX is.
    assign digit_clr = clear | rollover | min_hi_carry;

    bcd_digit #(.LIMIT(DIGIT_LIMIT)) u_sec_lo (
        .cin   (cin),
        .rst_n (rst_n),
        .clr   (digit_clr),
        .en    (count_en),
        .q     (sec_lo),
        .carry (sec_lo_carry)
    );

    bcd_digit #(.LIMIT(SEC_HI_LIMIT)) u_sec_hi (
        .cin   (cin),
        .rst_n (rst_n),
        .clr   (digit_clr),
        .en    (sec_lo_carry),
        .q     (sec_hi),
        .carry (sec_hi_carry)
    );

    bcd_digit #(.LIMIT(DIGIT_LIMIT)) u_min_lo (
        .cin   (cin),
        .rst_n (rst_n),
        .clr   (digit_clr),
        .en    (sec_hi_carry),
        .q     (min_lo),
        .carry (min_lo_carry)
    );

    bcd_digit #(.LIMIT(MIN_HI_MAX)) u_min_hi (
        .cin   (cin),
        .rst_n (rst_n),
        .clr   (digit_clr),
        .en    (min_lo_carry),
        .q     (min_hi),
        .carry (min_hi_carry)
    );

endmodule
